rv32i_lsu: RTL and testbench

RV32I_LSU -- requirements
Module: rv32i_lsu

---
 rtl/rv32i_lsu.sv | 228 ++++++++++++++++++++++
 tb/tb_rv32i_lsu.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu
// Brief    : RV32I load/store unit for a word-wide synchronous RAM, with
//            misaligned accesses split across two adjacent words.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_lsu #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_we,
    output logic [3:0]            d_be,
    output logic [31:0]           d_wdata,
    input  logic [31:0]           d_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_CAP  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] C_LAST_WORD = '1;

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    logic [1:0]            r_state, w_state_n;
    logic [2:0]            r_funct3;
    logic                  r_we, r_split, r_err;
    logic [1:0]            r_off;
    logic [31:0]           r_wdata, r_lo;
    logic [ADDR_WIDTH-1:0] r_word;

    logic [ADDR_WIDTH-1:0] r_d_addr, w_d_addr_n;
    logic                  r_d_we, w_d_we_n;
    logic [3:0]            r_d_be, w_d_be_n;
    logic [31:0]           r_d_wdata, w_d_wdata_n;
    logic                  r_rsp_valid, w_rsp_valid_n;
    logic                  r_rsp_err, w_rsp_err_n;
    logic [31:0]           r_rsp_rdata, w_rsp_rdata_n;

    logic                  w_accept, w_req_split, w_req_bad_f3, w_req_hi_bad, w_req_err;
    logic [ADDR_WIDTH-1:0] w_req_word;
    logic [7:0]            w_req_be8, w_be8;
    logic [5:0]            w_hi_shamt;
    logic [31:0]           w_hi, w_lo, w_shifted, w_load_data;

    // Request decode, evaluated against the live request bus
    assign w_accept     = (r_state == S_IDLE) & req_valid;
    assign w_req_word   = req_addr[ADDR_WIDTH+1:2];
    assign w_req_split  = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4;
    assign w_req_bad_f3 = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110));
    assign w_req_hi_bad = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    assign w_req_err    = w_req_bad_f3 | w_req_hi_bad | (w_req_split & (w_req_word == C_LAST_WORD));
    assign w_req_be8    = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];

    // Second-access lanes/data come from the registered request
    assign w_be8      = {4'b0000, size_mask(r_funct3)} << r_off;
    assign w_hi_shamt = 6'd32 - {1'b0, r_off, 3'b000};

    // Load result: {hi,lo} window shifted down to the addressed byte
    assign w_hi      = r_split ? d_rdata : 32'd0;
    assign w_lo      = r_split ? r_lo : d_rdata;
    assign w_shifted = 32'({w_hi, w_lo} >> {r_off, 3'b000});

    always_comb begin
        w_load_data = 32'd0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = w_shifted;
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        w_state_n     = r_state;
        w_d_addr_n    = r_d_addr;
        w_d_we_n      = r_d_we;
        w_d_be_n      = r_d_be;
        w_d_wdata_n   = r_d_wdata;
        w_rsp_valid_n = 1'b0;
        w_rsp_err_n   = r_rsp_err;
        w_rsp_rdata_n = r_rsp_rdata;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_n  = S_ACC0;
                    w_d_addr_n = w_req_word;
                    w_d_we_n   = req_we & ~w_req_err;
                    w_d_be_n   = 4'b0000;
                    if (req_we & ~w_req_err) begin
                        w_d_be_n    = w_req_be8[3:0];
                        w_d_wdata_n = req_wdata << {req_addr[1:0], 3'b000};
                    end
                end
            end
            S_ACC0: begin
                if (r_err) begin
                    w_state_n = S_CAP;
                end else if (r_split) begin
                    w_state_n  = S_ACC1;
                    w_d_addr_n = r_word + ADDR_WIDTH'(1);
                    if (r_we) begin
                        w_d_be_n    = w_be8[7:4];
                        w_d_wdata_n = r_wdata >> w_hi_shamt;
                    end
                end else if (r_we) begin
                    w_state_n     = S_IDLE;
                    w_d_we_n      = 1'b0;
                    w_d_be_n      = 4'b0000;
                    w_rsp_valid_n = 1'b1;
                    w_rsp_err_n   = 1'b0;
                    w_rsp_rdata_n = 32'd0;
                end else begin
                    w_state_n = S_CAP;
                end
            end
            S_ACC1: begin
                if (r_we) begin
                    w_state_n     = S_IDLE;
                    w_d_we_n      = 1'b0;
                    w_d_be_n      = 4'b0000;
                    w_rsp_valid_n = 1'b1;
                    w_rsp_err_n   = 1'b0;
                    w_rsp_rdata_n = 32'd0;
                end else begin
                    w_state_n = S_CAP;
                end
            end
            S_CAP: begin
                w_state_n     = S_IDLE;
                w_rsp_valid_n = 1'b1;
                w_rsp_err_n   = r_err;
                w_rsp_rdata_n = r_err ? 32'd0 : w_load_data;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_d_addr    <= '0;
            r_d_we      <= 1'b0;
            r_d_be      <= 4'b0000;
            r_d_wdata   <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_state     <= w_state_n;
            r_d_addr    <= w_d_addr_n;
            r_d_we      <= w_d_we_n;
            r_d_be      <= w_d_be_n;
            r_d_wdata   <= w_d_wdata_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_err   <= w_rsp_err_n;
            r_rsp_rdata <= w_rsp_rdata_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct3 <= 3'd0;
            r_we     <= 1'b0;
            r_off    <= 2'd0;
            r_wdata  <= 32'd0;
            r_word   <= '0;
            r_split  <= 1'b0;
            r_err    <= 1'b0;
            r_lo     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_we     <= req_we;
                r_off    <= req_addr[1:0];
                r_wdata  <= req_wdata;
                r_word   <= w_req_word;
                r_split  <= w_req_split;
                r_err    <= w_req_err;
            end
            // Word A arrives from the RAM while the A+1 read is in flight
            if (r_state == S_ACC1) begin
                r_lo <= d_rdata;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign d_addr    = r_d_addr;
    assign d_we      = r_d_we;
    assign d_be      = r_d_be;
    assign d_wdata   = r_d_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_lsu
// Brief    : Self-checking bench for rv32i_lsu against a byte-addressed model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_lsu;

    localparam int AW        = 15;
    localparam int NWORDS    = 1 << AW;
    localparam int MEM_BYTES = 1 << (AW + 2);

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid, req_ready, req_we;
    logic [2:0]     req_funct3;
    logic [31:0]    req_addr, req_wdata;
    logic           rsp_valid, rsp_err;
    logic [31:0]    rsp_rdata;
    logic [AW-1:0]  d_addr;
    logic           d_we;
    logic [3:0]     d_be;
    logic [31:0]    d_wdata, d_rdata;

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int w1_writes = 0;

    logic [31:0] ram     [0:NWORDS-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];

    rv32i_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .d_addr     (d_addr),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Synchronous RAM: registered read, byte-enabled write
    initial begin
        for (int w = 0; w < NWORDS; w++) ram[w] = init_word(w);
        forever begin
            @(posedge clk);
            d_rdata <= ram[d_addr];
            if (d_we === 1'b1) begin
                for (int i = 0; i < 4; i++)
                    if (d_be[i]) ram[d_addr][8*i +: 8] = d_wdata[8*i +: 8];
                wr_count++;
                if (d_addr == AW'(1)) w1_writes++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Byte-level reference of the architectural memory and response
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd,
                         output int lat, output int nwr);
        int size;
        logic valid, split;
        logic [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        valid = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        err   = !valid || (longint'(addr) + longint'(size) > longint'(MEM_BYTES));
        rd    = 32'd0;
        nwr   = 0;
        lat   = 2;
        if (!err) begin
            split = ((addr % 4) + size) > 4;
            if (we) begin
                lat = split ? 2 : 1;
                nwr = split ? 2 : 1;
                for (int i = 0; i < size; i++) ref_mem[addr + i] = wd[8*i +: 8];
            end else begin
                lat = split ? 3 : 2;
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
                case (f3)
                    3'd0:    rd = v[7]  ? (v | 32'hFFFF_FF00) : v;
                    3'd1:    rd = v[15] ? (v | 32'hFFFF_0000) : v;
                    default: rd = v;
                endcase
            end
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Full transaction: returns latency (0 = timed out), response and write count
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int nwr);
        int w0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        w0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_accept: got rsp_valid=%b req_ready=%b expected 0 0",
                     rsp_valid, req_ready);
        end
        lat = 0; rd = 32'hx; er = 1'bx;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
            end
        end
        nwr = wr_count - w0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, d_we, d_be, d_addr, d_wdata, rsp_valid, rsp_err, rsp_rdata} !==
            {1'b1, 1'b0, 4'b0, {AW{1'b0}}, 32'd0, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL reset_state: got ready=%b we=%b be=%b addr=%h wdata=%h v=%b e=%b rd=%h expected 1 0 0 0 0 0 0 0",
                     req_ready, d_we, d_be, d_addr, d_wdata, rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_store_aligned;
        logic e; logic [31:0] r; int l, n;
        model(1'b1, 3'd2, 32'h10, 32'h1122_3344, e, r, l, n);
        drive_req(1'b1, 3'd2, 32'h10, 32'h1122_3344);
        checks++;
        if (d_addr !== AW'(4) || d_be !== 4'b1111 || d_wdata !== 32'h1122_3344 || d_we !== 1'b1) begin
            failures++;
            $display("FAIL sw_bus: got addr=%h be=%b wdata=%h we=%b expected 0004 1111 11223344 1",
                     d_addr, d_be, d_wdata, d_we);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || d_we !== 1'b0) begin
            failures++;
            $display("FAIL sw_rsp: got valid=%b err=%b we=%b expected 1 0 0", rsp_valid, rsp_err, d_we);
        end
    endtask

    task automatic test_load_byte;
        int l, n; logic [31:0] r; logic e;
        logic em; logic [31:0] rm; int lm, nm;
        model(1'b1, 3'd2, 32'h10, 32'h80FF_0000, em, rm, lm, nm);
        do_req(1'b1, 3'd2, 32'h10, 32'h80FF_0000, l, r, e, n);
        do_req(1'b0, 3'd0, 32'h13, 32'd0, l, r, e, n);
        checks++;
        if (l != 2 || r !== 32'hFFFF_FF80 || e !== 1'b0) begin
            failures++;
            $display("FAIL lb_sext: got lat=%0d rdata=%h err=%b expected 2 ffffff80 0", l, r, e);
        end
        do_req(1'b0, 3'd4, 32'h13, 32'd0, l, r, e, n);
        checks++;
        if (l != 2 || r !== 32'h0000_0080 || e !== 1'b0) begin
            failures++;
            $display("FAIL lbu_zext: got lat=%0d rdata=%h err=%b expected 2 00000080 0", l, r, e);
        end
    endtask

    task automatic test_split_store;
        logic e; logic [31:0] r; int l, n;
        model(1'b1, 3'd1, 32'h0B, 32'h0000_BEEF, e, r, l, n);
        drive_req(1'b1, 3'd1, 32'h0B, 32'h0000_BEEF);
        checks++;
        if (d_addr !== AW'(2) || d_be !== 4'b1000 || d_wdata !== 32'hEF00_0000 || d_we !== 1'b1) begin
            failures++;
            $display("FAIL sh_access1: got addr=%h be=%b wdata=%h we=%b expected 0002 1000 ef000000 1",
                     d_addr, d_be, d_wdata, d_we);
        end
        @(posedge clk); #1;
        checks++;
        if (d_addr !== AW'(3) || d_be !== 4'b0001 || d_wdata !== 32'h0000_00BE || d_we !== 1'b1 ||
            rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL sh_access2: got addr=%h be=%b wdata=%h we=%b v=%b expected 0003 0001 000000be 1 0",
                     d_addr, d_be, d_wdata, d_we, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || d_we !== 1'b0 || d_be !== 4'b0000) begin
            failures++;
            $display("FAIL sh_rsp: got valid=%b we=%b be=%b expected 1 0 0000", rsp_valid, d_we, d_be);
        end
    endtask

    task automatic test_split_load;
        int l, n; logic [31:0] r; logic e;
        logic em; logic [31:0] rm; int lm, nm;
        model(1'b1, 3'd2, 32'h0C, 32'hAABB_CCDD, em, rm, lm, nm);
        do_req(1'b1, 3'd2, 32'h0C, 32'hAABB_CCDD, l, r, e, n);
        model(1'b1, 3'd2, 32'h10, 32'h1122_3344, em, rm, lm, nm);
        do_req(1'b1, 3'd2, 32'h10, 32'h1122_3344, l, r, e, n);
        drive_req(1'b0, 3'd2, 32'h0E, 32'd0);
        // A store held on the bus while busy must be ignored
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        checks++;
        if (d_addr !== AW'(3) || d_we !== 1'b0 || d_be !== 4'b0000) begin
            failures++;
            $display("FAIL lw_access1: got addr=%h we=%b be=%b expected 0003 0 0000", d_addr, d_we, d_be);
        end
        @(posedge clk); #1;
        checks++;
        if (d_addr !== AW'(4) || d_we !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL lw_access2: got addr=%h we=%b v=%b expected 0004 0 0", d_addr, d_we, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || d_we !== 1'b0) begin
            failures++;
            $display("FAIL lw_early: got v=%b we=%b expected 0 0", rsp_valid, d_we);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h3344_AABB || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL lw_split: got v=%b rdata=%h err=%b expected 1 3344aabb 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge clk); #1;
        checks++;
        if (d_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h3344_AABB) begin
            failures++;
            $display("FAIL ignore_busy_req: got we=%b ready=%b v=%b rdata=%h expected 0 1 0 3344aabb",
                     d_we, req_ready, rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_errors;
        int l, n; logic [31:0] r; logic e;
        drive_req(1'b0, 3'd2, 32'h0002_0000, 32'd0);
        checks++;
        if (d_we !== 1'b0) begin
            failures++;
            $display("FAIL err_we0: got %b expected 0", d_we);
        end
        @(posedge clk); #1;
        checks++;
        if (d_we !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_we1: got we=%b v=%b expected 0 0", d_we, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            failures++;
            $display("FAIL err_hi_addr: got v=%b err=%b rdata=%h expected 1 1 00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        do_req(1'b1, 3'd2, 32'(MEM_BYTES - 2), 32'h1234_5678, l, r, e, n);
        checks++;
        if (l != 2 || e !== 1'b1 || r !== 32'd0 || n != 0) begin
            failures++;
            $display("FAIL err_wrap: got lat=%0d err=%b rdata=%h writes=%0d expected 2 1 0 0", l, e, r, n);
        end
        do_req(1'b0, 3'd3, 32'h4, 32'd0, l, r, e, n);
        checks++;
        if (l != 2 || e !== 1'b1 || r !== 32'd0) begin
            failures++;
            $display("FAIL err_load_f3: got lat=%0d err=%b rdata=%h expected 2 1 0", l, e, r);
        end
        do_req(1'b1, 3'd4, 32'h4, 32'hFFFF_FFFF, l, r, e, n);
        checks++;
        if (l != 2 || e !== 1'b1 || n != 0) begin
            failures++;
            $display("FAIL err_store_f3: got lat=%0d err=%b writes=%0d expected 2 1 0", l, e, n);
        end
    endtask

    task automatic test_random;
        int l, n, lm, nm, sel;
        logic [31:0] r, rm, addr, wd;
        logic e, em, we;
        logic [2:0] f3;
        for (int t = 0; t < 300; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      addr = 32'($urandom_range(0, 63));
            else if (sel < 9) addr = 32'(MEM_BYTES) - 32'($urandom_range(1, 8));
            else              addr = $urandom | 32'h0002_0000;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            model(we, f3, addr, wd, em, rm, lm, nm);
            do_req(we, f3, addr, wd, l, r, e, n);
            checks++;
            if (l != lm || e !== em || r !== rm || n != nm) begin
                failures++;
                $display("FAIL rand_%0d we=%b f3=%0d addr=%h: got lat=%0d err=%b rdata=%h writes=%0d expected %0d %b %h %0d",
                         t, we, f3, addr, l, e, r, n, lm, em, rm, nm);
            end
        end
        @(posedge clk); #1;
        n = 0;
        for (int b = 0; b < 128; b++)
            if (ram[b / 4][8*(b % 4) +: 8] !== ref_mem[b]) n++;
        for (int b = MEM_BYTES - 64; b < MEM_BYTES; b++)
            if (ram[b / 4][8*(b % 4) +: 8] !== ref_mem[b]) n++;
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL ram_contents: got %0d differing bytes expected 0", n);
        end
    endtask

    task automatic test_reset_mid;
        int l, n, w1, nrsp;
        logic [31:0] r; logic e;
        do_req(1'b1, 3'd2, 32'h04, 32'hCAFE_F00D, l, r, e, n);
        drive_req(1'b1, 3'd2, 32'h01, 32'h1234_5678);
        checks++;
        if (d_addr !== AW'(0) || d_be !== 4'b1110 || d_we !== 1'b1) begin
            failures++;
            $display("FAIL rst_access1: got addr=%h be=%b we=%b expected 0000 1110 1", d_addr, d_be, d_we);
        end
        w1 = w1_writes;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || d_we !== 1'b0 || d_be !== 4'b0000 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got ready=%b we=%b be=%b v=%b expected 1 0 0000 0",
                     req_ready, d_we, d_be, rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nrsp = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) nrsp++;
        end
        checks++;
        if (nrsp != 0 || w1_writes != w1 || ram[1] !== 32'hCAFE_F00D || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_abandon: got rsp=%0d word1_writes=%0d word1=%h ready=%b expected 0 %0d cafef00d 1",
                     nrsp, w1_writes - w1, ram[1], req_ready, 0);
        end
    endtask

    initial begin
        logic [31:0] iw;
        for (int w = 0; w < NWORDS; w++) begin
            iw = init_word(w);
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = iw[8*i +: 8];
        end
        test_reset;
        test_store_aligned;
        test_load_byte;
        test_split_store;
        test_split_load;
        test_errors;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
